jk_bank_driver: RTL and testbench
=================================

Name: jk_bank_driver

Overview:
- Drives the J/K inputs of an external bank of WIDTH JK flip-flops so the bank reaches a requested target word.
- Per-bit excitation comes from the JK excitation table, evaluated against live flop feedback.
- After driving, the block reads back Q and retries on mismatch, up to a limit.
- Sits between a control master (valid/ready request) and a register bank built from JK flops that share the same clock.

Parameters:
- WIDTH, 4: number of JK flops in the driven bank.
- MAX_RETRY, 2: extra drive attempts after the first. Total attempts = MAX_RETRY+1. A value of 0 is legal.

Ports:
- clock  input  1  rising-edge clock, shared with the driven bank
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request strobe
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_target  input  WIDTH  desired bank value
- jk_j  output  WIDTH  J inputs to bank
- jk_k  output  WIDTH  K inputs to bank
- jk_q  input  WIDTH  Q feedback from bank
- busy  output  1  high in DRIVE or CHECK
- done  output  1  one-cycle pulse: bank matches target
- err  output  1  one-cycle pulse: retries exhausted
- last_mismatch  output  WIDTH  target XOR jk_q at the final CHECK of the last request

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (asynchronous, effective immediately):
  - state=IDLE; jk_j=jk_k=0; done=err=0; busy=0.
  - last_mismatch=0; target register=0; retry count=0.
  - Reset mid-operation aborts the transfer. No done/err is generated for it.
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: capture req_target, clear retry count, go to DRIVE.
  - At that same edge, register jk_j/jk_k from req_target and current jk_q.
- DRIVE (exactly one cycle):
  - jk_j/jk_k hold the excitation values.
  - The bank samples them at the closing edge.
  - At that edge jk_j/jk_k return to 0 (hold); go to CHECK.
- CHECK (one cycle): compare jk_q with the captured target, combinationally.
  - Match: go to IDLE; done=1 for the next cycle; last_mismatch=0.
  - Mismatch and retry count < MAX_RETRY: increment count; re-register jk_j/jk_k from target and current jk_q; go to DRIVE.
  - Mismatch and count == MAX_RETRY: go to IDLE; err=1 for the next cycle; last_mismatch = target^jk_q.
- Excitation per bit i, with don't-cares resolved to 0 by default:
  - q=0, t=0: J=0, K=0
  - q=0, t=1: J=1, K=0
  - q=1, t=0: J=0, K=1
  - q=1, t=1: J=0, K=0
- jk_j/jk_k are registered outputs and are 0 in every state other than DRIVE.
- J=1 and K=1 are never asserted together on a bit unless the optional feature is compiled in.
- Latency:
  - Accept edge T0, DRIVE in cycle 1, CHECK in cycle 2.
  - done/err high in cycle 3, which is an IDLE cycle.
  - Best case is 3 cycles accept→done. Each retry adds 2 cycles.
- Back-to-back: a request presented during the done/err cycle is accepted (IDLE, ready=1). done/err still deassert after one cycle.
- Target equal to current Q: still goes through DRIVE with J=K=0, then CHECK, then done.
- req_target changes after acceptance have no effect; only the captured target is used.
- req_valid while busy is ignored (ready=0). It is not queued.

Optional Feature:
- Macro: JK_TOGGLE_EXCITE_EN.
- Defined: don't-cares resolve to toggle. Every bit that differs from its target is driven J=1, K=1; equal bits are driven 0/0.
- Undefined: set/reset excitation as in the table above, with J=K=1 never asserted.
- Handshake, timing, retry and mismatch behaviour are identical in both builds.

Test Plan:
- Reset; bank Q=0000; request 1010 → DRIVE cycle j=1010, k=0000. Q becomes 1010. done=1 exactly 3 cycles after accept; err=0; last_mismatch=0000.
- Q=1100, request 0110 → j=0010, k=1000. Q becomes 0110; done.
- Bench forces Q[0] stuck at 0; request 0001 with MAX_RETRY=2 → three DRIVE cycles, each j=0001, k=0000. err pulse at cycle 7; last_mismatch=0001; done never asserts.
- Q=0101, request 0101 → DRIVE with j=k=0000; done at cycle 3. Then a new request of 0000 held during the done cycle is accepted: j=0000, k=0101.
- Assert reset during DRIVE → jk_j/jk_k drop to 0 asynchronously. No done/err. After release, req_ready=1 and busy=0.
- With JK_TOGGLE_EXCITE_EN, Q=1100, request 0110 → j=1010, k=1010. Q becomes 0110; done.

Source files
------------

// File: rtl/jk_bank_driver.sv
// Drives J/K of an external JK flop bank to a target word, with readback and retry.
// Build option JK_TOGGLE_EXCITE_EN: differing bits are driven J=K=1 (toggle).
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] jk_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] last_mismatch
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_target;
  logic [RW-1:0]    r_retry;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_last_mismatch;

  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_exc_j;
  logic [WIDTH-1:0] w_exc_k;
  logic [WIDTH-1:0] w_mismatch;

  // In IDLE the excitation is built from the incoming request, else from the captured target.
  assign w_tgt      = (r_state == S_IDLE) ? req_target : r_target;
  assign w_mismatch = r_target ^ jk_q;

`ifdef JK_TOGGLE_EXCITE_EN
  assign w_exc_j = w_tgt ^ jk_q;
  assign w_exc_k = w_tgt ^ jk_q;
`else
  assign w_exc_j = w_tgt & ~jk_q;
  assign w_exc_k = ~w_tgt & jk_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_target        <= '0;
      r_retry         <= '0;
      r_j             <= '0;
      r_k             <= '0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_last_mismatch <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_j    <= '0;
      r_k    <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_target <= req_target;
            r_retry  <= '0;
            r_j      <= w_exc_j;
            r_k      <= w_exc_k;
            r_state  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_mismatch == '0) begin
            r_state         <= S_IDLE;
            r_done          <= 1'b1;
            r_last_mismatch <= '0;
          end else if (r_retry < RETRY_MAX) begin
            r_retry <= r_retry + RW'(1);
            r_j     <= w_exc_j;
            r_k     <= w_exc_k;
            r_state <= S_DRIVE;
          end else begin
            r_state         <= S_IDLE;
            r_err           <= 1'b1;
            r_last_mismatch <= w_mismatch;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign jk_j          = r_j;
  assign jk_k          = r_k;
  assign done          = r_done;
  assign err           = r_err;
  assign last_mismatch = r_last_mismatch;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver with a behavioural JK bank model.
// Honours JK_TOGGLE_EXCITE_EN for the expected excitation values.
module tb_jk_bank_driver;

`ifdef JK_TOGGLE_EXCITE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_target;
  logic [3:0] jk_j;
  logic [3:0] jk_k;
  logic [3:0] jk_q;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] last_mismatch;

  logic [3:0] bank_q;
  logic [3:0] stuck;
  logic [3:0] ld_val;
  logic       ld_en;

  int n_cmp;
  int n_bad;

  jk_bank_driver #(
    .WIDTH(4),
    .MAX_RETRY(2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_target   (req_target),
    .jk_j         (jk_j),
    .jk_k         (jk_k),
    .jk_q         (jk_q),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .last_mismatch(last_mismatch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External JK bank; stuck bits read back as 0
  assign jk_q = bank_q & ~stuck;

  always @(posedge clock) begin
    if (ld_en) begin
      bank_q <= ld_val;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case ({jk_j[i], jk_k[i]})
          2'b10:   bank_q[i] <= 1'b1;
          2'b01:   bank_q[i] <= 1'b0;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: ;
        endcase
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic load_q(input logic [3:0] v);
    @(negedge clock);
    ld_en  = 1'b1;
    ld_val = v;
    @(negedge clock);
    ld_en  = 1'b0;
  endtask

  // Present a request at the current negedge; returns at the DRIVE-cycle negedge
  task automatic start_req(input logic [3:0] t);
    req_valid  = 1'b1;
    req_target = t;
    cyc();
    req_valid  = 1'b0;
    req_target = ~t;
  endtask

  task automatic run_ok(input string tag, input logic [3:0] t,
                        input logic [3:0] ej, input logic [3:0] ek,
                        input logic [3:0] eq);
    start_req(t);
    check_eq({tag, ".j"}, 32'(jk_j), 32'(ej));
    check_eq({tag, ".k"}, 32'(jk_k), 32'(ek));
    check_eq({tag, ".busy1"}, 32'(busy), 32'd1);
    check_eq({tag, ".ready1"}, 32'(req_ready), 32'd0);
    cyc();
    check_eq({tag, ".jchk"}, 32'(jk_j), 32'd0);
    check_eq({tag, ".done2"}, 32'(done), 32'd0);
    cyc();
    check_eq({tag, ".done3"}, 32'(done), 32'd1);
    check_eq({tag, ".err3"}, 32'(err), 32'd0);
    check_eq({tag, ".lm"}, 32'(last_mismatch), 32'd0);
    check_eq({tag, ".q"}, 32'(jk_q), 32'(eq));
    check_eq({tag, ".ready3"}, 32'(req_ready), 32'd1);
    cyc();
    check_eq({tag, ".done4"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dn;
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_target = 4'h0;
    ld_en      = 1'b0;
    ld_val     = 4'h0;
    stuck      = 4'h0;

    cyc();
    check_eq("rst.ready", 32'(req_ready), 32'd1);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.j", 32'(jk_j), 32'd0);
    check_eq("rst.k", 32'(jk_k), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.err", 32'(err), 32'd0);
    check_eq("rst.lm", 32'(last_mismatch), 32'd0);
    load_q(4'b0000);
    reset = 1'b0;
    cyc();

    // Basic set from all-zero bank
    run_ok("t1", 4'b1010, 4'b1010, TOG ? 4'b1010 : 4'b0000, 4'b1010);

    // Mixed set/reset
    load_q(4'b1100);
    run_ok("t2", 4'b0110, TOG ? 4'b1010 : 4'b0010, 4'b1010 & {4{TOG}} | 4'b1000 & {4{!TOG}}, 4'b0110);

    // Stuck bit: three attempts then err at cycle 7
    load_q(4'b0000);
    stuck = 4'b0001;
    start_req(4'b0001);
    dn = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 1 || c == 3 || c == 5) begin
        check_eq($sformatf("t3.j%0d", c), 32'(jk_j), 32'b0001);
        check_eq($sformatf("t3.k%0d", c), 32'(jk_k), TOG ? 32'b0001 : 32'b0000);
      end
      if (c == 7) begin
        check_eq("t3.err", 32'(err), 32'd1);
        check_eq("t3.lm", 32'(last_mismatch), 32'b0001);
        check_eq("t3.busy7", 32'(busy), 32'd0);
      end else begin
        check_eq($sformatf("t3.noerr%0d", c), 32'(err), 32'd0);
      end
      if (done) dn++;
      if (c < 7) cyc();
    end
    check_eq("t3.nodone", 32'(dn), 32'd0);
    cyc();
    check_eq("t3.errpulse", 32'(err), 32'd0);
    stuck = 4'b0000;

    // Target equals Q, then back-to-back request during done cycle
    load_q(4'b0101);
    start_req(4'b0101);
    check_eq("t4.j", 32'(jk_j), 32'd0);
    check_eq("t4.k", 32'(jk_k), 32'd0);
    cyc();
    cyc();
    check_eq("t4.done", 32'(done), 32'd1);
    check_eq("t4.lm", 32'(last_mismatch), 32'd0);
    check_eq("t4.ready", 32'(req_ready), 32'd1);
    start_req(4'b0000);
    check_eq("t4.done_off", 32'(done), 32'd0);
    check_eq("t4.j2", 32'(jk_j), TOG ? 32'b0101 : 32'b0000);
    check_eq("t4.k2", 32'(jk_k), 32'b0101);
    cyc();
    cyc();
    check_eq("t4.done2", 32'(done), 32'd1);
    check_eq("t4.q2", 32'(jk_q), 32'b0000);
    cyc();

    // Asynchronous reset in DRIVE
    load_q(4'b0000);
    start_req(4'b1111);
    check_eq("t5.j", 32'(jk_j), 32'b1111);
    #2 reset = 1'b1;
    #1;
    check_eq("t5.j_async", 32'(jk_j), 32'd0);
    check_eq("t5.k_async", 32'(jk_k), 32'd0);
    check_eq("t5.busy_async", 32'(busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      cyc();
      check_eq($sformatf("t5.done%0d", c), 32'(done), 32'd0);
      check_eq($sformatf("t5.err%0d", c), 32'(err), 32'd0);
    end
    reset = 1'b0;
    cyc();
    check_eq("t5.ready", 32'(req_ready), 32'd1);
    check_eq("t5.busy", 32'(busy), 32'd0);
    cyc();
    cyc();
    check_eq("t5.done_end", 32'(done), 32'd0);
    check_eq("t5.err_end", 32'(err), 32'd0);
    check_eq("t5.q_held", 32'(jk_q), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
